instr_fetch_stage: RTL

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

---
 rtl/fetch_pkg.sv | 29 ++
 rtl/instr_queue.sv | 71 +++++++
 rtl/instr_fetch_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: redirect source
// encodings, instruction-memory latency, in-flight token and FSM types.
package fetch_pkg;

    localparam logic [1:0] SEL_PC_BRANCH = 2'b00;
    localparam logic [1:0] SEL_PC_RESET  = 2'b01;
    localparam logic [1:0] SEL_PC_ALU    = 2'b10;
    localparam logic [1:0] SEL_PC_HOLD   = 2'b11;

    // Cycles from a fetch request to its instruction word on imem_rdata.
    localparam int IMEM_LATENCY = 2;

    // One outstanding fetch: whether the slot is occupied and which PC it fetches.
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } fetch_token_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fetch_state_t;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_queue.sv
// Synchronous FIFO holding fetched {instruction, pc} entries.
// Flush has priority over push and pop; a push into a full queue is only
// accepted when a pop happens in the same cycle. The head entry is read
// combinationally so the consumer sees it in the cycle after the push.
module instr_queue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == DEPTH_W);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array: written on accepted push, contents need no reset since
    // the count gates everything downstream.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: issues word fetches to a fixed-latency memory,
// tracks outstanding requests as a token pipeline, and buffers returned
// words in an in-order queue for the execute stage.
// Optional build macro FETCH_PERF_CNT_EN adds o_squash_cnt, counting
// in-flight fetches killed by redirects.
module instr_fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int          QDEPTH       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load_pc,
    input  logic [1:0]  i_sel_pc,
    input  logic [31:0] i_pc_branch_in,
    input  logic [31:0] i_pc_alu_in,
    output logic        o_imem_rd,
    output logic [31:0] o_imem_addr,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_instr_out,
    output logic [31:0] o_pc_out,
    output logic        o_instr_valid,
    input  logic        i_instr_ready
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0] o_squash_cnt
`endif
);

    localparam int          CW       = $clog2(QDEPTH) + 1;
    localparam int          LAST     = IMEM_LATENCY - 1;
    localparam logic [CW:0] QDEPTH_W = QDEPTH[CW:0];

    fetch_state_t  r_state;
    logic [31:0]   r_fetch_pc;
    fetch_token_t  r_tok [IMEM_LATENCY];

    logic [31:0]   w_target;
    logic [CW-1:0] w_q_count;
    logic [CW-1:0] w_inflight;
    logic [CW:0]   w_occupancy;
    logic          w_issue;
    logic          w_push;
    logic          w_pop;
    logic          w_q_empty;
    logic          w_q_full;
    logic [63:0]   w_q_head;
    logic [63:0]   w_q_wdata;

    // Redirect target selection; HOLD re-fetches from the current fetch_pc.
    always_comb begin
        w_target = r_fetch_pc;
        case (i_sel_pc)
            SEL_PC_BRANCH: w_target = i_pc_branch_in;
            SEL_PC_RESET:  w_target = RESET_VECTOR;
            SEL_PC_ALU:    w_target = i_pc_alu_in;
            default:       w_target = r_fetch_pc;
        endcase
    end

    // Number of requests currently in flight to the instruction memory.
    always_comb begin
        w_inflight = '0;
        for (int i = 0; i < IMEM_LATENCY; i++) begin
            w_inflight = w_inflight + CW'(r_tok[i].valid);
        end
    end

    // Credit rule: queued plus outstanding never exceeds the queue depth,
    // so every returning word is guaranteed a slot.
    assign w_occupancy = {1'b0, w_q_count} + {1'b0, w_inflight};
    assign w_issue     = (r_state == ST_RUN) && !i_load_pc && (w_occupancy < QDEPTH_W);

    // A redirect kills returning data and blocks the consumer's pop.
    assign w_push    = r_tok[LAST].valid && !i_load_pc;
    assign w_pop     = !w_q_empty && i_instr_ready && !i_load_pc;
    assign w_q_wdata = {i_imem_rdata, r_tok[LAST].pc};

    // Control FSM and fetch address: the first redirect after reset starts fetching.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_fetch_pc <= align_word(RESET_VECTOR);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_load_pc) begin
                        r_state    <= ST_RUN;
                        r_fetch_pc <= align_word(w_target);
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    if (i_load_pc) begin
                        r_fetch_pc <= align_word(w_target);
                    end else if (w_issue) begin
                        r_fetch_pc <= r_fetch_pc + 32'd4;
                    end
                end
            endcase
        end
    end

    // In-flight token pipeline: stage 0 captures the issued request, the last
    // stage lines up with the memory's read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IMEM_LATENCY; i++) begin
                r_tok[i] <= '0;
            end
        end else if (i_load_pc) begin
            for (int i = 0; i < IMEM_LATENCY; i++) begin
                r_tok[i] <= '0;
            end
        end else begin
            r_tok[0] <= {w_issue, r_fetch_pc};
            for (int i = 1; i < IMEM_LATENCY; i++) begin
                r_tok[i] <= r_tok[i-1];
            end
        end
    end

    instr_queue #(
        .DEPTH (QDEPTH),
        .WIDTH (64)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (i_load_pc),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (w_q_wdata),
        .o_head  (w_q_head),
        .o_empty (w_q_empty),
        .o_full  (w_q_full),
        .o_count (w_q_count)
    );

    assign o_imem_rd     = w_issue;
    assign o_imem_addr   = r_fetch_pc;
    assign o_instr_valid = !w_q_empty;
    assign o_instr_out   = w_q_empty ? 32'd0 : w_q_head[63:32];
    assign o_pc_out      = w_q_empty ? 32'd0 : w_q_head[31:0];

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_squash_cnt;
    logic [16:0] w_squash_sum;

    assign w_squash_sum = {1'b0, r_squash_cnt} + 17'(w_inflight);

    // Saturating count of outstanding fetches thrown away by redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_squash_cnt <= '0;
        end else if (i_load_pc) begin
            r_squash_cnt <= w_squash_sum[16] ? 16'hFFFF : w_squash_sum[15:0];
        end
    end

    assign o_squash_cnt = r_squash_cnt;
`endif

endmodule
